// File: rtl/ook_packet_decoder_if.sv
// Receiver-side bundle for the OOK packet decoder: raw envelope in, decoded packet and status out.
// The decoder uses the master modport; the consumer of decoded packets uses slave.
interface ook_packet_decoder_if #(
  parameter int unsigned PACKET_BITS = 66
);
  logic                   ook_in;
  logic [PACKET_BITS-1:0] data;
  logic                   valid;
  logic                   error;
  logic                   busy;

  modport master (input ook_in, output data, valid, error, busy);
  modport slave  (output ook_in, input data, valid, error, busy);
endinterface

// File: rtl/ook_packet_decoder.sv
// Recovers pulse-width-coded fan-remote packets from an asynchronous OOK envelope.
// Each decision is registered, so it shows up three clk edges after the input level changes.
module ook_packet_decoder #(
  parameter int unsigned PACKET_BITS = 66,
  parameter int unsigned GAP_CYCLES  = 20000,
  parameter int unsigned SHORT_MIN   = 1000,
  parameter int unsigned SHORT_MAX   = 1700,
  parameter int unsigned LONG_MIN    = 2300,
  parameter int unsigned LONG_MAX    = 3000,
  parameter int unsigned LOW_MAX     = 3000
) (
  input logic                  clk,
  input logic                  reset,
  ook_packet_decoder_if.master bus
);
  localparam int unsigned CntW = $clog2(GAP_CYCLES + 1);
  localparam int unsigned BitW = $clog2(PACKET_BITS + 1);

  localparam logic [CntW-1:0] GapMax   = CntW'(GAP_CYCLES);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);
  localparam logic [CntW-1:0] ShortMin = CntW'(SHORT_MIN);
  localparam logic [CntW-1:0] ShortMax = CntW'(SHORT_MAX);
  localparam logic [CntW-1:0] LongMin  = CntW'(LONG_MIN);
  localparam logic [CntW-1:0] LongMax  = CntW'(LONG_MAX);
  localparam logic [CntW-1:0] LowMax   = CntW'(LOW_MAX);
  localparam logic [BitW-1:0] LastBit  = BitW'(PACKET_BITS - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StHigh, StLow} state_e;

  state_e                 state_q;
  logic                   ook_meta_q, ook_s, ook_d;
  logic [CntW-1:0]        width_q, gap_q;
  logic [BitW-1:0]        nbits_q;
  logic [PACKET_BITS-2:0] shift_q;
  logic [PACKET_BITS-1:0] data_q;
  logic                   valid_q, error_q;

  logic rise, fall, is_short, is_long;

  assign rise     = ook_s & ~ook_d;
  assign fall     = ~ook_s & ook_d;
  assign is_short = (width_q >= ShortMin) && (width_q <= ShortMax);
  assign is_long  = (width_q >= LongMin) && (width_q <= LongMax);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ook_meta_q <= 1'b0;
      ook_s      <= 1'b0;
      ook_d      <= 1'b0;
      width_q    <= '0;
      gap_q      <= '0;
      nbits_q    <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      ook_meta_q <= bus.ook_in;
      ook_s      <= ook_meta_q;
      ook_d      <= ook_s;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;

      if (rise || fall) begin
        width_q <= CntW'(1);
      end else if (width_q != GapMax) begin
        width_q <= width_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (ook_s) begin
            gap_q <= '0;
          end else if (gap_q >= GapLast) begin
            gap_q   <= '0;
            state_q <= StArmed;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        StArmed: begin
          if (rise) begin
            nbits_q <= '0;
            shift_q <= '0;
            state_q <= StHigh;
          end
        end
        StHigh: begin
          if (fall && (is_short || is_long)) begin
            nbits_q <= nbits_q + 1'b1;
            if (nbits_q == LastBit) begin
              data_q  <= {shift_q, is_long};
              valid_q <= 1'b1;
              gap_q   <= CntW'(1);  // the final falling-edge cycle already counts as low
              state_q <= StIdle;
            end else begin
              shift_q <= {shift_q[PACKET_BITS-3:0], is_long};
              state_q <= StLow;
            end
          end else if (fall || (width_q > LongMax)) begin
            error_q <= 1'b1;
            gap_q   <= '0;
            state_q <= StIdle;
          end
        end
        StLow: begin
          if (width_q > LowMax) begin
            // Seeding with the low width times the next gap from the last falling edge
            error_q <= 1'b1;
            gap_q   <= width_q;
            state_q <= StIdle;
          end else if (rise) begin
            state_q <= StHigh;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.error = error_q;
  assign bus.busy  = (state_q == StHigh) || (state_q == StLow);
endmodule
